// File: rtl/miriscv_rvfi_trace_fifo.sv
// RVFI retirement trace buffer: formats one record per retired instruction,
// queues it in a DEPTH-entry FIFO with registered outputs and counts records lost on overflow.
module miriscv_rvfi_trace_fifo #(
  parameter int XLEN   = 32,
  parameter int DEPTH  = 4,
  parameter int DROP_W = 16
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                ret_valid_i,
  input  logic [31:0]         ret_insn_i,
  input  logic [XLEN-1:0]     ret_pc_rdata_i,
  input  logic [XLEN-1:0]     ret_pc_wdata_i,
  input  logic                ret_trap_i,
  input  logic                ret_intr_i,
  input  logic                ret_rd_we_i,
  input  logic [4:0]          ret_rd_addr_i,
  input  logic [XLEN-1:0]     ret_rd_wdata_i,
  input  logic                ret_mem_req_i,
  input  logic                ret_mem_we_i,
  input  logic [1:0]          ret_mem_size_i,
  input  logic [XLEN-1:0]     ret_mem_addr_i,
  input  logic [XLEN-1:0]     ret_mem_wdata_i,
  input  logic [XLEN-1:0]     ret_mem_rdata_i,
  input  logic                rvfi_ready_i,
  output logic                rvfi_valid_o,
  output logic [63:0]         rvfi_order_o,
  output logic [31:0]         rvfi_insn_o,
  output logic                rvfi_trap_o,
  output logic                rvfi_intr_o,
  output logic [XLEN-1:0]     rvfi_pc_rdata_o,
  output logic [XLEN-1:0]     rvfi_pc_wdata_o,
  output logic [4:0]          rvfi_rd_addr_o,
  output logic [XLEN-1:0]     rvfi_rd_wdata_o,
  output logic [XLEN-1:0]     rvfi_mem_addr_o,
  output logic [XLEN/8-1:0]   rvfi_mem_rmask_o,
  output logic [XLEN/8-1:0]   rvfi_mem_wmask_o,
  output logic [XLEN-1:0]     rvfi_mem_rdata_o,
  output logic [XLEN-1:0]     rvfi_mem_wdata_o,
  output logic [1:0]          rvfi_mode_o,
  output logic [1:0]          rvfi_ixl_o,
  output logic                full_o,
  output logic [DROP_W-1:0]   drop_cnt_o
);

  localparam int XB    = XLEN / 8;
  localparam int OFF_W = $clog2(XB);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [63:0]     order;
    logic [31:0]     insn;
    logic            trap;
    logic            intr;
    logic [XLEN-1:0] pc_rdata;
    logic [XLEN-1:0] pc_wdata;
    logic [4:0]      rd_addr;
    logic [XLEN-1:0] rd_wdata;
    logic [XLEN-1:0] mem_addr;
    logic [XB-1:0]   mem_rmask;
    logic [XB-1:0]   mem_wmask;
    logic [XLEN-1:0] mem_rdata;
    logic [XLEN-1:0] mem_wdata;
  } rec_t;

  rec_t             mem_q [DEPTH];
  rec_t             out_q, out_d;
  rec_t             rec_s;
  logic             valid_q, valid_d;
  logic             full_q, full_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] rd_ptr_nx_s;
  logic [63:0]      order_q, order_d;
  logic [DROP_W-1:0] drop_q, drop_d;
  logic             deq_s, enq_s, drop_s, at_full_s;
  logic [OFF_W-1:0] off_s;
  logic [7:0]       base_s;
  logic [XB-1:0]    mask_s;
  logic [XLEN-1:0]  lane_data_s;

  // Format the retiring instruction into a lane-aligned trace record.
  always_comb begin
    rec_s       = '0;
    off_s       = ret_mem_addr_i[OFF_W-1:0];
    case (ret_mem_size_i)
      2'd0:    base_s = 8'h01;
      2'd1:    base_s = 8'h03;
      2'd2:    base_s = 8'h0F;
      2'd3:    base_s = (XLEN == 64) ? 8'hFF : 8'h00;
      default: base_s = 8'h00;
    endcase
    mask_s      = XB'(base_s << off_s);
    lane_data_s = (ret_mem_we_i ? ret_mem_wdata_i : ret_mem_rdata_i) << {off_s, 3'b000};

    rec_s.order    = order_q;
    rec_s.insn     = ret_insn_i;
    rec_s.trap     = ret_trap_i;
    rec_s.intr     = ret_intr_i;
    rec_s.pc_rdata = ret_pc_rdata_i;
    rec_s.pc_wdata = ret_pc_wdata_i;
    if (ret_rd_we_i) begin
      rec_s.rd_addr  = ret_rd_addr_i;
      rec_s.rd_wdata = (ret_rd_addr_i != 5'd0) ? ret_rd_wdata_i : '0;
    end else begin
      rec_s.rd_addr  = 5'd0;
      rec_s.rd_wdata = '0;
    end
    if (ret_mem_req_i) begin
      rec_s.mem_addr = ret_mem_addr_i;
      if (ret_mem_we_i) begin
        rec_s.mem_wmask = mask_s;
        rec_s.mem_wdata = lane_data_s;
      end else begin
        rec_s.mem_rmask = mask_s;
        rec_s.mem_rdata = lane_data_s;
      end
    end else begin
      rec_s.mem_addr = '0;
    end
  end

  // Queue control; the output register always mirrors the FIFO head.
  always_comb begin
    at_full_s   = (count_q == CNT_W'(DEPTH));
    deq_s       = valid_q & rvfi_ready_i;
    enq_s       = ret_valid_i & (~at_full_s | deq_s);
    drop_s      = ret_valid_i & ~enq_s;
    rd_ptr_nx_s = rd_ptr_q + PTR_W'(1);

    case ({enq_s, deq_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    wr_ptr_d = enq_s ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = deq_s ? rd_ptr_nx_s : rd_ptr_q;
    full_d   = (count_d == CNT_W'(DEPTH));
    order_d  = ret_valid_i ? order_q + 64'd1 : order_q;
    if (drop_s && (drop_q != {DROP_W{1'b1}})) begin
      drop_d = drop_q + DROP_W'(1);
    end else begin
      drop_d = drop_q;
    end

    out_d   = out_q;
    valid_d = valid_q;
    if (deq_s) begin
      if (count_q > CNT_W'(1)) begin
        out_d   = mem_q[rd_ptr_nx_s];
        valid_d = 1'b1;
      end else if (enq_s) begin
        out_d   = rec_s;
        valid_d = 1'b1;
      end else begin
        out_d   = '0;
        valid_d = 1'b0;
      end
    end else if (!valid_q && enq_s) begin
      out_d   = rec_s;
      valid_d = 1'b1;
    end else begin
      out_d   = out_q;
      valid_d = valid_q;
    end
  end

  // Control state and registered outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      order_q  <= 64'd0;
      drop_q   <= '0;
      full_q   <= 1'b0;
      valid_q  <= 1'b0;
      out_q    <= '0;
    end else begin
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      order_q  <= order_d;
      drop_q   <= drop_d;
      full_q   <= full_d;
      valid_q  <= valid_d;
      out_q    <= out_d;
    end
  end

  // Record storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk_i) begin
    if (enq_s) begin
      mem_q[wr_ptr_q] <= rec_s;
    end
  end

  assign rvfi_valid_o     = valid_q;
  assign rvfi_order_o     = out_q.order;
  assign rvfi_insn_o      = out_q.insn;
  assign rvfi_trap_o      = out_q.trap;
  assign rvfi_intr_o      = out_q.intr;
  assign rvfi_pc_rdata_o  = out_q.pc_rdata;
  assign rvfi_pc_wdata_o  = out_q.pc_wdata;
  assign rvfi_rd_addr_o   = out_q.rd_addr;
  assign rvfi_rd_wdata_o  = out_q.rd_wdata;
  assign rvfi_mem_addr_o  = out_q.mem_addr;
  assign rvfi_mem_rmask_o = out_q.mem_rmask;
  assign rvfi_mem_wmask_o = out_q.mem_wmask;
  assign rvfi_mem_rdata_o = out_q.mem_rdata;
  assign rvfi_mem_wdata_o = out_q.mem_wdata;
  assign rvfi_mode_o      = 2'd3;
  assign rvfi_ixl_o       = (XLEN == 64) ? 2'd2 : 2'd1;
  assign full_o           = full_q;
  assign drop_cnt_o       = drop_q;

endmodule

// File: tb/tb_miriscv_rvfi_trace_fifo.sv
// Scoreboard bench for the RVFI trace FIFO (XLEN=32, DEPTH=4) plus a DROP_W=2
// instance sharing the same stimulus to exercise drop-counter saturation.
module tb_miriscv_rvfi_trace_fifo;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_i, ret_valid_i, ret_trap_i, ret_intr_i, ret_rd_we_i;
  logic        ret_mem_req_i, ret_mem_we_i, rvfi_ready_i;
  logic [31:0] ret_insn_i, ret_pc_rdata_i, ret_pc_wdata_i, ret_rd_wdata_i;
  logic [31:0] ret_mem_addr_i, ret_mem_wdata_i, ret_mem_rdata_i;
  logic [4:0]  ret_rd_addr_i;
  logic [1:0]  ret_mem_size_i;

  logic        rvfi_valid_o, rvfi_trap_o, rvfi_intr_o, full_o;
  logic [63:0] rvfi_order_o;
  logic [31:0] rvfi_insn_o, rvfi_pc_rdata_o, rvfi_pc_wdata_o, rvfi_rd_wdata_o;
  logic [31:0] rvfi_mem_addr_o, rvfi_mem_rdata_o, rvfi_mem_wdata_o;
  logic [4:0]  rvfi_rd_addr_o;
  logic [3:0]  rvfi_mem_rmask_o, rvfi_mem_wmask_o;
  logic [1:0]  rvfi_mode_o, rvfi_ixl_o;
  logic [15:0] drop_cnt_o;

  logic        s_valid, s_trap, s_intr, s_full;
  logic [63:0] s_order;
  logic [31:0] s_insn, s_pcr, s_pcw, s_rdd, s_maddr, s_mrd, s_mwd;
  logic [4:0]  s_rda;
  logic [3:0]  s_rmask, s_wmask;
  logic [1:0]  s_mode, s_ixl, s_drop;

  miriscv_rvfi_trace_fifo #(.XLEN(32), .DEPTH(4), .DROP_W(16)) u_dut (
    .clk_i(clk), .rst_i(rst_i), .ret_valid_i(ret_valid_i), .ret_insn_i(ret_insn_i),
    .ret_pc_rdata_i(ret_pc_rdata_i), .ret_pc_wdata_i(ret_pc_wdata_i),
    .ret_trap_i(ret_trap_i), .ret_intr_i(ret_intr_i), .ret_rd_we_i(ret_rd_we_i),
    .ret_rd_addr_i(ret_rd_addr_i), .ret_rd_wdata_i(ret_rd_wdata_i),
    .ret_mem_req_i(ret_mem_req_i), .ret_mem_we_i(ret_mem_we_i), .ret_mem_size_i(ret_mem_size_i),
    .ret_mem_addr_i(ret_mem_addr_i), .ret_mem_wdata_i(ret_mem_wdata_i),
    .ret_mem_rdata_i(ret_mem_rdata_i), .rvfi_ready_i(rvfi_ready_i),
    .rvfi_valid_o(rvfi_valid_o), .rvfi_order_o(rvfi_order_o), .rvfi_insn_o(rvfi_insn_o),
    .rvfi_trap_o(rvfi_trap_o), .rvfi_intr_o(rvfi_intr_o),
    .rvfi_pc_rdata_o(rvfi_pc_rdata_o), .rvfi_pc_wdata_o(rvfi_pc_wdata_o),
    .rvfi_rd_addr_o(rvfi_rd_addr_o), .rvfi_rd_wdata_o(rvfi_rd_wdata_o),
    .rvfi_mem_addr_o(rvfi_mem_addr_o), .rvfi_mem_rmask_o(rvfi_mem_rmask_o),
    .rvfi_mem_wmask_o(rvfi_mem_wmask_o), .rvfi_mem_rdata_o(rvfi_mem_rdata_o),
    .rvfi_mem_wdata_o(rvfi_mem_wdata_o), .rvfi_mode_o(rvfi_mode_o), .rvfi_ixl_o(rvfi_ixl_o),
    .full_o(full_o), .drop_cnt_o(drop_cnt_o)
  );

  miriscv_rvfi_trace_fifo #(.XLEN(32), .DEPTH(4), .DROP_W(2)) u_sat (
    .clk_i(clk), .rst_i(rst_i), .ret_valid_i(ret_valid_i), .ret_insn_i(ret_insn_i),
    .ret_pc_rdata_i(ret_pc_rdata_i), .ret_pc_wdata_i(ret_pc_wdata_i),
    .ret_trap_i(ret_trap_i), .ret_intr_i(ret_intr_i), .ret_rd_we_i(ret_rd_we_i),
    .ret_rd_addr_i(ret_rd_addr_i), .ret_rd_wdata_i(ret_rd_wdata_i),
    .ret_mem_req_i(ret_mem_req_i), .ret_mem_we_i(ret_mem_we_i), .ret_mem_size_i(ret_mem_size_i),
    .ret_mem_addr_i(ret_mem_addr_i), .ret_mem_wdata_i(ret_mem_wdata_i),
    .ret_mem_rdata_i(ret_mem_rdata_i), .rvfi_ready_i(rvfi_ready_i),
    .rvfi_valid_o(s_valid), .rvfi_order_o(s_order), .rvfi_insn_o(s_insn),
    .rvfi_trap_o(s_trap), .rvfi_intr_o(s_intr),
    .rvfi_pc_rdata_o(s_pcr), .rvfi_pc_wdata_o(s_pcw),
    .rvfi_rd_addr_o(s_rda), .rvfi_rd_wdata_o(s_rdd),
    .rvfi_mem_addr_o(s_maddr), .rvfi_mem_rmask_o(s_rmask),
    .rvfi_mem_wmask_o(s_wmask), .rvfi_mem_rdata_o(s_mrd),
    .rvfi_mem_wdata_o(s_mwd), .rvfi_mode_o(s_mode), .rvfi_ixl_o(s_ixl),
    .full_o(s_full), .drop_cnt_o(s_drop)
  );

  typedef struct packed {
    logic [63:0] order;
    logic [31:0] insn;
    logic        trap;
    logic        intr;
    logic [31:0] pc_r;
    logic [31:0] pc_w;
    logic [4:0]  rd_addr;
    logic [31:0] rd_wdata;
    logic [31:0] mem_addr;
    logic [3:0]  rmask;
    logic [3:0]  wmask;
    logic [31:0] rdata;
    logic [31:0] wdata;
  } exp_t;

  exp_t        sb_q[$];
  logic [63:0] m_order;
  int unsigned m_drop, m_drop2;
  int          n_total = 0;
  int          n_bad   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_total++;
    if (obs !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp_v, $time);
    end
  endtask

  // Expected record built lane by lane from the current retirement inputs.
  function automatic exp_t mk_exp();
    exp_t        e;
    int          off, nbytes;
    logic [31:0] src, dat;
    logic [3:0]  msk;
    e          = '0;
    e.order    = m_order;
    e.insn     = ret_insn_i;
    e.trap     = ret_trap_i;
    e.intr     = ret_intr_i;
    e.pc_r     = ret_pc_rdata_i;
    e.pc_w     = ret_pc_wdata_i;
    e.rd_addr  = ret_rd_we_i ? ret_rd_addr_i : 5'd0;
    e.rd_wdata = (ret_rd_we_i && ret_rd_addr_i != 5'd0) ? ret_rd_wdata_i : 32'd0;
    if (ret_mem_req_i) begin
      off = int'(ret_mem_addr_i[1:0]);
      case (ret_mem_size_i)
        2'd0:    nbytes = 1;
        2'd1:    nbytes = 2;
        2'd2:    nbytes = 4;
        default: nbytes = 0;
      endcase
      src = ret_mem_we_i ? ret_mem_wdata_i : ret_mem_rdata_i;
      dat = 32'd0;
      msk = 4'd0;
      for (int b = 0; b < 4; b++) begin
        if (b >= off) begin
          dat[8*b +: 8] = src[8*(b-off) +: 8];
          if (b - off < nbytes) msk[b] = 1'b1;
        end
      end
      e.mem_addr = ret_mem_addr_i;
      if (ret_mem_we_i) begin
        e.wmask = msk;
        e.wdata = dat;
      end else begin
        e.rmask = msk;
        e.rdata = dat;
      end
    end
    return e;
  endfunction

  task automatic check_state();
    exp_t h;
    chk("valid", rvfi_valid_o, sb_q.size() != 0);
    chk("full", full_o, sb_q.size() == 4);
    chk("drop_cnt", drop_cnt_o, m_drop);
    chk("drop_cnt_w2", s_drop, m_drop2);
    chk("mode", rvfi_mode_o, 2'd3);
    chk("ixl", rvfi_ixl_o, 2'd1);
    if (sb_q.size() != 0) begin
      h = sb_q[0];
      chk("order", rvfi_order_o, h.order);
      chk("insn", rvfi_insn_o, h.insn);
      chk("trap_intr", {rvfi_trap_o, rvfi_intr_o}, {h.trap, h.intr});
      chk("pc", {rvfi_pc_rdata_o, rvfi_pc_wdata_o}, {h.pc_r, h.pc_w});
      chk("rd", {rvfi_rd_addr_o, rvfi_rd_wdata_o}, {h.rd_addr, h.rd_wdata});
      chk("mem_addr", rvfi_mem_addr_o, h.mem_addr);
      chk("masks", {rvfi_mem_rmask_o, rvfi_mem_wmask_o}, {h.rmask, h.wmask});
      chk("mem_data", {rvfi_mem_rdata_o, rvfi_mem_wdata_o}, {h.rdata, h.wdata});
    end
  endtask

  // Advance the model across one rising edge, then check at the falling edge.
  task automatic step();
    logic deq, enq;
    if (rst_i) begin
      sb_q.delete();
      m_order = 64'd0;
      m_drop  = 0;
      m_drop2 = 0;
    end else begin
      deq = (sb_q.size() != 0) && rvfi_ready_i;
      enq = ret_valid_i && ((sb_q.size() < 4) || deq);
      if (ret_valid_i && !enq) begin
        if (m_drop < 65535) m_drop++;
        if (m_drop2 < 3) m_drop2++;
      end
      if (deq) void'(sb_q.pop_front());
      if (enq) sb_q.push_back(mk_exp());
      if (ret_valid_i) m_order++;
    end
    @(negedge clk);
    check_state();
  endtask

  task automatic drive(input logic v, input logic [31:0] insn, input logic rdwe,
                       input logic [4:0] rda, input logic [31:0] rdd, input logic req,
                       input logic we, input logic [1:0] sz, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [31:0] rd);
    ret_valid_i     = v;
    ret_insn_i      = insn;
    ret_pc_rdata_i  = {insn[29:0], 2'b00};
    ret_pc_wdata_i  = {insn[29:0], 2'b00} + 32'd4;
    ret_trap_i      = insn[0];
    ret_intr_i      = insn[1];
    ret_rd_we_i     = rdwe;
    ret_rd_addr_i   = rda;
    ret_rd_wdata_i  = rdd;
    ret_mem_req_i   = req;
    ret_mem_we_i    = we;
    ret_mem_size_i  = sz;
    ret_mem_addr_i  = addr;
    ret_mem_wdata_i = wd;
    ret_mem_rdata_i = rd;
  endtask

  task automatic idle();
    drive(1'b0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 2'd0, 32'd0, 32'd0, 32'd0);
  endtask

  task automatic retire_n(input int n, input int base);
    for (int i = 0; i < n; i++) begin
      drive(1'b1, 32'h0000_1000 + 32'(base + i), 1'b1, 5'(i + 1), 32'hA000_0000 + 32'(i),
            1'b0, 1'b0, 2'd0, 32'd0, 32'd0, 32'd0);
      step();
    end
  endtask

  initial begin
    int unsigned d0;
    rst_i        = 1'b1;
    rvfi_ready_i = 1'b1;
    idle();
    m_order = 64'd0;
    m_drop  = 0;
    m_drop2 = 0;
    @(negedge clk);
    step();
    step();
    chk("rst_valid", rvfi_valid_o, 1'b0);
    chk("rst_order", rvfi_order_o, 64'd0);
    chk("rst_data", {rvfi_insn_o, rvfi_mem_rmask_o, rvfi_mem_rdata_o}, 68'd0);
    chk("rst_full", full_o, 1'b0);
    rst_i = 1'b0;

    // Byte load at offset 3
    drive(1'b1, 32'h0000_0003, 1'b1, 5'd7, 32'h0000_005A, 1'b1, 1'b0, 2'd0,
          32'h0000_1003, 32'd0, 32'h0000_005A);
    step();
    chk("ld_valid", rvfi_valid_o, 1'b1);
    chk("ld_rmask", rvfi_mem_rmask_o, 4'h8);
    chk("ld_rdata", rvfi_mem_rdata_o, 32'h5A00_0000);
    chk("ld_wmask", rvfi_mem_wmask_o, 4'h0);
    chk("ld_order", rvfi_order_o, 64'd0);
    idle();
    step();

    // Halfword store, rd write to x0
    drive(1'b1, 32'h0000_0023, 1'b1, 5'd0, 32'h0000_00FF, 1'b1, 1'b1, 2'd1,
          32'h0000_0002, 32'h0000_1234, 32'd0);
    step();
    chk("st_wmask", rvfi_mem_wmask_o, 4'hC);
    chk("st_wdata", rvfi_mem_wdata_o, 32'h1234_0000);
    chk("st_rd_addr", rvfi_rd_addr_o, 5'd0);
    chk("st_rd_wdata", rvfi_rd_wdata_o, 32'd0);
    idle();
    step();

    // Random traffic with random back-pressure, including size 3 accesses
    for (int i = 0; i < 40; i++) begin
      rvfi_ready_i = ($urandom_range(0, 3) != 0);
      drive(($urandom_range(0, 9) < 7), $urandom(), 1'($urandom()), 5'($urandom()), $urandom(),
            1'($urandom()), 1'($urandom()), 2'($urandom()), $urandom(), $urandom(), $urandom());
      step();
    end
    idle();
    rvfi_ready_i = 1'b1;
    for (int i = 0; i < 6; i++) step();

    // Overflow: 6 retirements into a stalled 4-deep buffer
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    rvfi_ready_i = 1'b0;
    for (int i = 0; i < 6; i++) begin
      retire_n(1, 100 + i);
      if (i == 3) chk("ovf_full", full_o, 1'b1);
    end
    chk("ovf_drops", drop_cnt_o, 16'd2);
    idle();
    rvfi_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("ovf_order", rvfi_order_o, 64'(i));
      step();
    end
    chk("ovf_stop", rvfi_valid_o, 1'b0);

    // Full with simultaneous enqueue/dequeue every cycle
    rvfi_ready_i = 1'b0;
    retire_n(4, 200);
    d0 = m_drop;
    rvfi_ready_i = 1'b1;
    retire_n(8, 300);
    chk("stream_full", full_o, 1'b1);
    chk("stream_nodrop", drop_cnt_o, 16'(d0));
    idle();
    for (int i = 0; i < 5; i++) step();

    // Reset with records buffered
    rvfi_ready_i = 1'b0;
    retire_n(3, 400);
    idle();
    rst_i = 1'b1;
    step();
    chk("rst_mid_valid", rvfi_valid_o, 1'b0);
    rst_i = 1'b0;
    rvfi_ready_i = 1'b1;
    retire_n(1, 500);
    chk("rst_mid_order", rvfi_order_o, 64'd0);
    chk("rst_mid_drop", drop_cnt_o, 16'd0);
    idle();
    step();

    // Five drops saturate the 2-bit counter
    rvfi_ready_i = 1'b0;
    retire_n(9, 600);
    chk("sat_drop_w2", s_drop, 2'd3);
    chk("sat_drop_w16", drop_cnt_o, 16'd5);
    idle();
    rvfi_ready_i = 1'b1;
    for (int i = 0; i < 5; i++) step();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
